arb4_hold: RTL and testbench

Four-requester arbiter with grant hold and bounded tenure, sequencing access to one shared resource. Requests are picked by a 4-to-2 priority pick, MSB first, with optional rotation. Grants are registered and held until the owner releases or the hold limit expires. The block sits between four client request lines and the resource's select/enable inputs.

---
 rtl/arb4_pkg.sv | 16 +
 rtl/arb4_pick.sv | 36 +++
 rtl/arb4_hold.sv | 99 +++++++++
 tb/tb_arb4_hold.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb4_pkg.sv
// Shared definitions for the four-requester hold arbiter: state encoding,
// requester count and a one-hot helper.
package arb4_pkg;

  localparam int ARB_N = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [ARB_N-1:0] onehot(input logic [1:0] id);
    return {{(ARB_N-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/arb4_pick.sv
// Combinational MSB-first pick over a request vector rotated by base; the
// winning index is un-rotated so it names the original requester.
module arb4_pick
  import arb4_pkg::*;
(
  input  logic [ARB_N-1:0] req,
  input  logic [1:0]       base,
  output logic [1:0]       pick_id,
  output logic             pick_valid
);

  logic [ARB_N-1:0] rot;
  logic [1:0]       enc;

  // rot[i] = req[(i + base) mod 4], so rot[3] is the requester just below base
  always_comb begin
    rot = req;
    case (base)
      2'd0:    rot = req;
      2'd1:    rot = {req[0],   req[3:1]};
      2'd2:    rot = {req[1:0], req[3:2]};
      default: rot = {req[2:0], req[3]};
    endcase
  end

  always_comb begin
    enc = 2'd0;
    if (rot[3])      enc = 2'd3;
    else if (rot[2]) enc = 2'd2;
    else if (rot[1]) enc = 2'd1;
  end

  assign pick_id    = enc + base;
  assign pick_valid = |req;

endmodule

// File: rtl/arb4_hold.sv
// Four-requester arbiter with registered grant, hold until release and an
// optional tenure limit. Define ARB4_ROUND_ROBIN_EN for rotating priority.
module arb4_hold
  import arb4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ARB_N-1:0] req,
  output logic [ARB_N-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             gnt_valid
);

  localparam int CW    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int LIM_I = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CW-1:0] LIMIT = CW'(LIM_I);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [ARB_N-1:0] gnt_q;
  logic [1:0]       id_q;
  logic             vld_q;

  logic [1:0]       base;
  logic [1:0]       pick_id;
  logic             pick_valid;
  logic             owner_req;
  logic             at_limit;

`ifdef ARB4_ROUND_ROBIN_EN
  logic [1:0] last_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 2'd0;
    end else if (state_q == ST_IDLE && pick_valid) begin
      last_q <= pick_id;
    end
  end

  assign base = last_q;
`else
  assign base = 2'd0;
`endif

  arb4_pick u_pick (
    .req       (req),
    .base      (base),
    .pick_id   (pick_id),
    .pick_valid(pick_valid)
  );

  assign owner_req = req[id_q];
  // With no limit the counter stays at zero and never triggers a release
  assign at_limit  = (MAX_HOLD != 0) && (cnt_q == LIMIT);
  assign cnt_d     = (MAX_HOLD != 0) ? cnt_q + CW'(1) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      id_q    <= 2'd0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_q   <= onehot(pick_id);
            id_q    <= pick_id;
            vld_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Owner drop wins over the limit; either way one idle cycle follows
          if (!owner_req || at_limit) begin
            gnt_q   <= '0;
            id_q    <= 2'd0;
            vld_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = vld_q;

endmodule

// File: tb/tb_arb4_hold.sv
// Self-checking bench for arb4_hold: three instances (limit 8, unlimited,
// limit 4) share stimulus and are compared against a tenure-level model.
module tb_arb4_hold;

`ifdef ARB4_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;

  logic [3:0] gnt8, gnt0, gnt4;
  logic [1:0] id8, id0, id4;
  logic       v8, v0, v4;

  arb4_hold #(.MAX_HOLD(8)) u_h8 (.clk(clk), .rst(rst), .req(req), .gnt(gnt8), .gnt_id(id8), .gnt_valid(v8));
  arb4_hold #(.MAX_HOLD(0)) u_h0 (.clk(clk), .rst(rst), .req(req), .gnt(gnt0), .gnt_id(id0), .gnt_valid(v0));
  arb4_hold #(.MAX_HOLD(4)) u_h4 (.clk(clk), .rst(rst), .req(req), .gnt(gnt4), .gnt_id(id4), .gnt_valid(v4));

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  bit mon_en = 1'b0;

  // Model: owner index (-1 = nobody), cycles granted so far, last winner
  int MH[3] = '{8, 0, 4};
  int m_owner[3];
  int m_held[3];
  int m_last[3];

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       v;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic int ref_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = RR ? ((last - k + 8) % 4) : (4 - k);
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_owner[i] = -1;
      m_held[i]  = 0;
      m_last[i]  = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (m_owner[i] < 0) begin
        int p;
        p = ref_pick(req, m_last[i]);
        if (p >= 0) begin
          m_owner[i] = p;
          m_held[i]  = 1;
          m_last[i]  = p;
        end
      end else if (!req[m_owner[i]]) begin
        m_owner[i] = -1;
      end else if (MH[i] != 0 && m_held[i] == MH[i]) begin
        m_owner[i] = -1;
      end else begin
        m_held[i]++;
      end
    end
  endtask

  function automatic logic [6:0] dut_out(input int i);
    case (i)
      0:       return {gnt8, id8, v8};
      1:       return {gnt0, id0, v0};
      default: return {gnt4, id4, v4};
    endcase
  endfunction

  function automatic logic [6:0] exp_out(input int i);
    logic [3:0] g;
    if (m_owner[i] < 0) return 7'd0;
    g = 4'b0001 << m_owner[i];
    return {g, 2'(m_owner[i]), 1'b1};
  endfunction

  task automatic monitor();
    for (int i = 0; i < 3; i++) begin
      logic [6:0] o;
      o = dut_out(i);
      chk($sformatf("model_inst%0d_t%0t", i, $time), o, exp_out(i));
      chk($sformatf("onehot_inst%0d_t%0t", i, $time), o[6:3], {3'b000, o[0]} << o[2:1]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    if (mon_en) monitor();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int         q[$];
    int         on_cnt;
    bit         prev_v;
    logic [1:0] b;

    tbl[0] = '{4'b0110, 4'b0100, 2'd2, 1'b1};
    tbl[1] = '{4'b0010, 4'b0000, 2'd0, 1'b0};
    tbl[2] = '{4'b0010, 4'b0010, 2'd1, 1'b1};
    tbl[3] = '{4'b0011, 4'b0010, 2'd1, 1'b1};
    tbl[4] = '{4'b0001, 4'b0000, 2'd0, 1'b0};
    tbl[5] = RR ? '{4'b1001, 4'b0001, 2'd0, 1'b1} : '{4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[6] = '{4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[7] = '{4'b0000, 4'b0000, 2'd0, 1'b0};

    req = 4'b0000;
    do_reset();
    mon_en = 1'b1;
    chk("reset_h8", {gnt8, id8, v8}, 7'd0);
    chk("reset_h0", {gnt0, id0, v0}, 7'd0);
    chk("reset_h4", {gnt4, id4, v4}, 7'd0);

    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("vec%0d", i), {gnt8, id8, v8}, {tbl[i].gnt, tbl[i].id, tbl[i].v});
    end

    // Tenure limit with a single persistent requester
    req = 4'b0001;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("hold8_c%0d", c), gnt8, (c == 8) ? 4'b0000 : 4'b0001);
      chk($sformatf("hold4_c%0d", c), gnt4, (c == 4 || c == 9) ? 4'b0000 : 4'b0001);
      chk($sformatf("hold0_c%0d", c), gnt0, 4'b0001);
      tick();
    end
    req = 4'b0000;
    tick();
    tick();

    // Unlimited hold
    req = 4'b1000;
    tick();
    for (int c = 0; c < 50; c++) begin
      chk($sformatf("unlim_c%0d", c), {gnt0, id0, v0}, {4'b1000, 2'd3, 1'b1});
      tick();
    end
    req = 4'b0000;
    tick();
    tick();

    // Forced-release fairness on the limit-4 instance
    do_reset();
    req = 4'b1001;
    prev_v = 1'b0;
    q.delete();
    for (int t = 0; t < 30; t++) begin
      tick();
      if (v4 && !prev_v) q.push_back(int'(id4));
      prev_v = v4;
    end
    chk("fair_count", q.size() >= 4, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fair_g%0d", i), (i < q.size()) ? q[i] : 7, RR ? ((i % 2 == 0) ? 3 : 0) : 3);
    req = 4'b0000;
    tick();
    tick();

    // Each owner drops after two cycles and re-raises after the gap
    do_reset();
    req = 4'b1111;
    q.delete();
    on_cnt = 0;
    for (int t = 0; t < 60 && q.size() < 5; t++) begin
      tick();
      if (v8) begin
        if (on_cnt == 0) q.push_back(int'(id8));
        on_cnt++;
        if (on_cnt == 2) req[id8] = 1'b0;
      end else begin
        on_cnt = 0;
        req = 4'b1111;
      end
    end
    chk("seq_count", q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("seq_g%0d", i), (i < q.size()) ? q[i] : 7, RR ? ((i == 4) ? 3 : 3 - i) : 3);

    // Asynchronous reset in the middle of a grant
    req = 4'b1111;
    tick();
    tick();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_gnt8", {gnt8, v8}, 5'd0);
    chk("arst_gnt0", {gnt0, v0}, 5'd0);
    chk("arst_gnt4", {gnt4, v4}, 5'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("arst_hold", {gnt8, id8, v8}, 7'd0);
    tick();
    chk("arst_regrant", {gnt8, id8, v8}, {4'b1000, 2'd3, 1'b1});

    // Random request activity against the model
    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(3) == 0) begin
        b = 2'($urandom_range(3));
        req[b] = ~req[b];
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
